// File: rtl/upg_boot_ctrl.sv
// upg_boot_ctrl: boot/load sequencer and memory write-port arbiter (define UPG_TIMEOUT_EN for load-idle timeout)
module upg_boot_ctrl #(
  parameter int ADDR_W         = 15,
  parameter int DATA_W         = 32,
  parameter int HOLD_CYCLES    = 16,
  parameter int TIMEOUT_CYCLES = 2300000
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              pg_req_i,
  input  logic              tgt_ram_i,
  input  logic              upg_wen_i,
  input  logic [ADDR_W-1:0] upg_adr_i,
  input  logic [DATA_W-1:0] upg_dat_i,
  input  logic              upg_done_i,
  input  logic              cpu_wen_i,
  input  logic [ADDR_W-1:0] cpu_adr_i,
  input  logic [DATA_W-1:0] cpu_dat_i,
  output logic              upg_rst_o,
  output logic              cpu_rst_o,
  output logic              rom_wen_o,
  output logic [ADDR_W-1:0] rom_adr_o,
  output logic [DATA_W-1:0] rom_dat_o,
  output logic              ram_wen_o,
  output logic [ADDR_W-1:0] ram_adr_o,
  output logic [DATA_W-1:0] ram_dat_o,
  output logic              busy_o,
  output logic [ADDR_W:0]   words_o,
  output logic              err_o
);
  typedef enum logic [2:0] {HOLD, RUN, ARM, LOAD, DRAIN} state_t;
  state_t st;
  logic s1, s2, pg_d, wen_d, tgt, cpu_rst_q, upg_rst_q, err, rise, wrise, tout, ld_rom, ld_ram;
  logic [15:0] hcnt;
  logic [ADDR_W:0] words;
  assign rise  = s2 & ~pg_d;
  assign wrise = upg_wen_i & ~wen_d;
`ifdef UPG_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES);
  logic [TW-1:0] tcnt;
  assign tout = !wrise && tcnt == TW'(TIMEOUT_CYCLES - 1);
  always_ff @(posedge clk)
    if (!rst_n || st != LOAD || wrise) tcnt <= '0;
    else tcnt <= tcnt + 1'b1;
`else
  assign tout = 1'b0;
`endif
  // cpu_rst_q/upg_rst_q are updated alongside every transition so the resets are glitch-free flops
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      st <= HOLD;
      hcnt <= '0;
      words <= '0;
      err <= 1'b0;
      s1 <= 1'b0;
      s2 <= 1'b0;
      pg_d <= 1'b0;
      wen_d <= 1'b0;
      tgt <= 1'b0;
      cpu_rst_q <= 1'b1;
      upg_rst_q <= 1'b1;
    end else begin
      s1 <= pg_req_i;
      s2 <= s1;
      pg_d <= s2;
      wen_d <= upg_wen_i;
      case (st)
        HOLD:
          if (hcnt == 16'(HOLD_CYCLES - 1)) begin
            st <= RUN;
            hcnt <= '0;
            cpu_rst_q <= 1'b0;
          end else hcnt <= hcnt + 1'b1;
        RUN:
          if (rise) begin
            st <= ARM;
            cpu_rst_q <= 1'b1;
          end
        ARM: begin
          tgt <= tgt_ram_i;
          words <= '0;
          err <= 1'b0;
          st <= LOAD;
          upg_rst_q <= 1'b0;
        end
        LOAD: begin
          if (wrise && words != '1) words <= words + 1'b1;
          if (upg_done_i) st <= DRAIN;
          else if (!s2 || tout) begin
            err <= 1'b1;
            st <= HOLD;
            upg_rst_q <= 1'b1;
          end
        end
        DRAIN:
          if (!s2) begin
            st <= HOLD;
            upg_rst_q <= 1'b1;
          end
        default: begin
          st <= HOLD;
          cpu_rst_q <= 1'b1;
          upg_rst_q <= 1'b1;
        end
      endcase
    end
  end
  assign ld_rom    = st == LOAD && !tgt;
  assign ld_ram    = st == LOAD && tgt;
  assign rom_wen_o = ld_rom & upg_wen_i;
  assign rom_adr_o = upg_adr_i;
  assign rom_dat_o = upg_dat_i;
  assign ram_wen_o = ld_ram ? upg_wen_i : (st == RUN) & cpu_wen_i;
  assign ram_adr_o = ld_ram ? upg_adr_i : cpu_adr_i;
  assign ram_dat_o = ld_ram ? upg_dat_i : cpu_dat_i;
  assign cpu_rst_o = cpu_rst_q;
  assign upg_rst_o = upg_rst_q;
  assign busy_o    = cpu_rst_q;
  assign words_o   = words;
  assign err_o     = err;
endmodule

// File: tb/tb_upg_boot_ctrl.sv
// tb_upg_boot_ctrl: scoreboard bench for upg_boot_ctrl (honours UPG_TIMEOUT_EN)
module tb_upg_boot_ctrl;
  localparam int AW = 15, DW = 32, HC = 16, TC = 100;
  logic clk = 0, rst_n = 0, pg_req_i = 0, tgt_ram_i = 0, upg_wen_i = 0, upg_done_i = 0, cpu_wen_i = 0;
  logic [AW-1:0] upg_adr_i = '0, cpu_adr_i = '0;
  logic [DW-1:0] upg_dat_i = '0, cpu_dat_i = '0;
  logic upg_rst_o, cpu_rst_o, rom_wen_o, ram_wen_o, busy_o, err_o;
  logic [AW-1:0] rom_adr_o, ram_adr_o;
  logic [DW-1:0] rom_dat_o, ram_dat_o;
  logic [AW:0] words_o;
  int tests = 0, fails = 0;
  logic [AW+DW-1:0] rom_q[$], ram_q[$], rom_e, ram_e;

  upg_boot_ctrl #(.ADDR_W(AW), .DATA_W(DW), .HOLD_CYCLES(HC), .TIMEOUT_CYCLES(TC)) dut (
    .clk(clk), .rst_n(rst_n), .pg_req_i(pg_req_i), .tgt_ram_i(tgt_ram_i),
    .upg_wen_i(upg_wen_i), .upg_adr_i(upg_adr_i), .upg_dat_i(upg_dat_i), .upg_done_i(upg_done_i),
    .cpu_wen_i(cpu_wen_i), .cpu_adr_i(cpu_adr_i), .cpu_dat_i(cpu_dat_i),
    .upg_rst_o(upg_rst_o), .cpu_rst_o(cpu_rst_o),
    .rom_wen_o(rom_wen_o), .rom_adr_o(rom_adr_o), .rom_dat_o(rom_dat_o),
    .ram_wen_o(ram_wen_o), .ram_adr_o(ram_adr_o), .ram_dat_o(ram_dat_o),
    .busy_o(busy_o), .words_o(words_o), .err_o(err_o)
  );

  always #5 clk = ~clk;

  // every forwarded write must match the oldest expected write for that port
  always @(negedge clk) begin
    if (rom_wen_o === 1'b1) begin
      tests++;
      if (rom_q.size() == 0) begin
        fails++;
        $display("FAIL rom_unexpected: got adr=%h dat=%h, want no write", rom_adr_o, rom_dat_o);
      end else begin
        rom_e = rom_q.pop_front();
        if ({rom_adr_o, rom_dat_o} !== rom_e) begin
          fails++;
          $display("FAIL rom_write: got %h_%h, want %h_%h", rom_adr_o, rom_dat_o, rom_e[AW+DW-1:DW], rom_e[DW-1:0]);
        end
      end
    end
    if (ram_wen_o === 1'b1) begin
      tests++;
      if (ram_q.size() == 0) begin
        fails++;
        $display("FAIL ram_unexpected: got adr=%h dat=%h, want no write", ram_adr_o, ram_dat_o);
      end else begin
        ram_e = ram_q.pop_front();
        if ({ram_adr_o, ram_dat_o} !== ram_e) begin
          fails++;
          $display("FAIL ram_write: got %h_%h, want %h_%h", ram_adr_o, ram_dat_o, ram_e[AW+DW-1:DW], ram_e[DW-1:0]);
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic wait_run(output int n);
    n = 0;
    while (cpu_rst_o === 1'b1 && n < 200) begin
      tick();
      n++;
    end
  endtask

  task automatic enter_load(input logic t);
    int n, nb;
    tgt_ram_i = t;
    pg_req_i = 1;
    n = 0;
    nb = 0;
    while (upg_rst_o === 1'b1 && n < 20) begin
      tick();
      n++;
      if (busy_o === 1'b1 && nb == 0) nb = n;
    end
    tests++;
    if (n != 4 || nb != 3) begin
      fails++;
      $display("FAIL enter_load: got load@%0d arm@%0d, want load@4 arm@3", n, nb);
    end
  endtask

  task automatic upg_write(input logic t, input logic [AW-1:0] a, input logic [DW-1:0] d, input int len);
    upg_adr_i = a;
    upg_dat_i = d;
    upg_wen_i = 1;
    for (int i = 0; i < len; i++) begin
      if (t) ram_q.push_back({a, d});
      else rom_q.push_back({a, d});
      tick();
    end
    upg_wen_i = 0;
    tick();
  endtask

  task automatic cpu_write(input logic [AW-1:0] a, input logic [DW-1:0] d);
    cpu_wen_i = 1;
    cpu_adr_i = a;
    cpu_dat_i = d;
    ram_q.push_back({a, d});
    #1;
    tests++;
    if (ram_wen_o !== 1'b1 || rom_wen_o !== 1'b0 || ram_adr_o !== a || ram_dat_o !== d) begin
      fails++;
      $display("FAIL run_write: got ram_wen=%b rom_wen=%b adr=%h dat=%h, want 1 0 %h %h",
               ram_wen_o, rom_wen_o, ram_adr_o, ram_dat_o, a, d);
    end
    tick();
    cpu_wen_i = 0;
  endtask

  task automatic test_reset;
    int n;
    logic upg_ok;
    rst_n = 0;
    pg_req_i = 0;
    repeat (3) tick();
    rst_n = 1;
    tests++;
    if ({cpu_rst_o, upg_rst_o, busy_o, err_o} !== 4'b1110 || words_o !== '0) begin
      fails++;
      $display("FAIL reset_state: got cpu/upg/busy/err=%b words=%0d, want 1110 0",
               {cpu_rst_o, upg_rst_o, busy_o, err_o}, words_o);
    end
    n = 0;
    upg_ok = 1;
    while (cpu_rst_o === 1'b1 && n < 200) begin
      tick();
      n++;
      if (upg_rst_o !== 1'b1) upg_ok = 0;
    end
    tests++;
    if (n != HC || !upg_ok) begin
      fails++;
      $display("FAIL hold_len: got %0d cycles upg_held=%b, want %0d 1", n, upg_ok, HC);
    end
    tests++;
    if (upg_rst_o !== 1'b1 || busy_o !== 1'b0) begin
      fails++;
      $display("FAIL run_state: got upg_rst=%b busy=%b, want 1 0", upg_rst_o, busy_o);
    end
  endtask

  task automatic test_run_write;
    cpu_write(15'h0010, 32'hDEADBEEF);
    cpu_write(15'h7fff, 32'h12345678);
  endtask

  task automatic test_rom_load;
    int n;
    enter_load(0);
    upg_write(0, 15'h0, 32'h1111_0000, 1);
    upg_write(0, 15'h1, 32'h2222_0001, 4);
    upg_write(0, 15'h2, 32'h3333_0002, 1);
    upg_done_i = 1;
    tick();
    upg_done_i = 0;
    tests++;
    if (words_o !== 3) begin
      fails++;
      $display("FAIL rom_words: got %0d, want 3", words_o);
    end
    upg_adr_i = 15'h5;
    upg_wen_i = 1;
    tick();
    upg_wen_i = 0;
    tests++;
    if ({upg_rst_o, cpu_rst_o, err_o} !== 3'b010 || words_o !== 3) begin
      fails++;
      $display("FAIL drain_state: got upg/cpu/err=%b words=%0d, want 010 3", {upg_rst_o, cpu_rst_o, err_o}, words_o);
    end
    pg_req_i = 0;
    wait_run(n);
    tests++;
    if (n != 3 + HC || upg_rst_o !== 1'b1 || words_o !== 3) begin
      fails++;
      $display("FAIL drain_exit: got %0d cycles upg_rst=%b words=%0d, want %0d 1 3", n, upg_rst_o, words_o, 3 + HC);
    end
  endtask

  task automatic test_ram_tgt_toggle;
    int n;
    enter_load(1);
    tgt_ram_i = 0;
    cpu_wen_i = 1;
    cpu_adr_i = 15'h55;
    cpu_dat_i = 32'hBAD0_BAD0;
    upg_write(1, 15'h100, 32'hA5A5_0100, 2);
    upg_adr_i = 15'h101;
    upg_dat_i = 32'h5A5A_0101;
    upg_wen_i = 1;
    upg_done_i = 1;
    ram_q.push_back({15'h101, 32'h5A5A_0101});
    #1;
    tests++;
    if (rom_wen_o !== 1'b0 || ram_wen_o !== 1'b1) begin
      fails++;
      $display("FAIL ram_target: got rom_wen=%b ram_wen=%b, want 0 1", rom_wen_o, ram_wen_o);
    end
    tick();
    upg_wen_i = 0;
    upg_done_i = 0;
    cpu_wen_i = 0;
    tests++;
    if (words_o !== 2) begin
      fails++;
      $display("FAIL ram_words: got %0d, want 2", words_o);
    end
    pg_req_i = 0;
    wait_run(n);
    tests++;
    if (n != 3 + HC) begin
      fails++;
      $display("FAIL ram_exit: got %0d cycles, want %0d", n, 3 + HC);
    end
  endtask

  task automatic test_abort;
    int n;
    enter_load(0);
    upg_write(0, 15'h7, 32'hCAFE_0007, 1);
    pg_req_i = 0;
    n = 0;
    while (upg_rst_o === 1'b0 && n < 20) begin
      tick();
      n++;
    end
    tests++;
    if (n != 3 || err_o !== 1'b1 || words_o !== 1 || cpu_rst_o !== 1'b1) begin
      fails++;
      $display("FAIL abort: got %0d cycles err=%b words=%0d cpu_rst=%b, want 3 1 1 1", n, err_o, words_o, cpu_rst_o);
    end
    wait_run(n);
    tests++;
    if (n != HC || err_o !== 1'b1) begin
      fails++;
      $display("FAIL abort_hold: got %0d cycles err=%b, want %0d 1", n, err_o, HC);
    end
    pg_req_i = 1;
    repeat (3) tick();
    tests++;
    if (cpu_rst_o !== 1'b1 || upg_rst_o !== 1'b1 || err_o !== 1'b1) begin
      fails++;
      $display("FAIL arm_state: got cpu/upg/err=%b, want 111", {cpu_rst_o, upg_rst_o, err_o});
    end
    tick();
    tests++;
    if (err_o !== 1'b0 || words_o !== 0 || upg_rst_o !== 1'b0) begin
      fails++;
      $display("FAIL arm_clear: got err=%b words=%0d upg_rst=%b, want 0 0 0", err_o, words_o, upg_rst_o);
    end
    upg_done_i = 1;
    tick();
    upg_done_i = 0;
    pg_req_i = 0;
    wait_run(n);
  endtask

  task automatic test_timeout;
    int n;
    enter_load(0);
`ifdef UPG_TIMEOUT_EN
    repeat (TC - 1) tick();
    tests++;
    if (err_o !== 1'b0 || upg_rst_o !== 1'b0) begin
      fails++;
      $display("FAIL timeout_early: got err=%b upg_rst=%b, want 0 0", err_o, upg_rst_o);
    end
    tick();
    tests++;
    if (err_o !== 1'b1 || upg_rst_o !== 1'b1) begin
      fails++;
      $display("FAIL timeout: got err=%b upg_rst=%b, want 1 1", err_o, upg_rst_o);
    end
    pg_req_i = 0;
    wait_run(n);
`else
    repeat (1000) tick();
    tests++;
    if (err_o !== 1'b0 || upg_rst_o !== 1'b0) begin
      fails++;
      $display("FAIL no_timeout: got err=%b upg_rst=%b, want 0 0", err_o, upg_rst_o);
    end
    upg_write(0, 15'h3e8, 32'h0000_03e8, 1);
    tests++;
    if (words_o !== 1) begin
      fails++;
      $display("FAIL late_write: got words=%0d, want 1", words_o);
    end
    upg_done_i = 1;
    tick();
    upg_done_i = 0;
    pg_req_i = 0;
    wait_run(n);
`endif
    tests++;
    if (cpu_rst_o !== 1'b0) begin
      fails++;
      $display("FAIL timeout_exit: got cpu_rst=%b after %0d cycles, want 0", cpu_rst_o, n);
    end
  endtask

  task automatic test_reset_mid_load;
    int n;
    enter_load(0);
    rst_n = 0;
    tick();
    tests++;
    if ({cpu_rst_o, upg_rst_o, err_o} !== 3'b110 || words_o !== 0) begin
      fails++;
      $display("FAIL reset_mid_load: got cpu/upg/err=%b words=%0d, want 110 0", {cpu_rst_o, upg_rst_o, err_o}, words_o);
    end
    rst_n = 1;
    wait_run(n);
    tests++;
    if (n != HC) begin
      fails++;
      $display("FAIL reset_hold: got %0d cycles, want %0d", n, HC);
    end
    repeat (10) tick();
    tests++;
    if (busy_o !== 1'b0) begin
      fails++;
      $display("FAIL level_at_entry: got busy=%b, want 0", busy_o);
    end
    pg_req_i = 0;
  endtask

  initial begin
    test_reset();
    test_run_write();
    test_rom_load();
    test_ram_tgt_toggle();
    test_abort();
    test_timeout();
    test_reset_mid_load();
    repeat (2) tick();
    tests++;
    if (rom_q.size() != 0 || ram_q.size() != 0) begin
      fails++;
      $display("FAIL scoreboard_drain: got rom=%0d ram=%0d pending, want 0 0", rom_q.size(), ram_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
